// File: rtl/arf_sequencer_pkg.sv
// Shared encodings for the address-register-file sequencer: opcodes, FunSel/RegSel/OutDSel
// codes, FSM states and the per-step control word.
package arf_ctrl_pkg;

  typedef enum logic [2:0] {
    OP_NOP   = 3'b000,
    OP_FETCH = 3'b001,
    OP_PUSH  = 3'b010,
    OP_POP   = 3'b011,
    OP_JUMP  = 3'b100,
    OP_LDAR  = 3'b101,
    OP_INIT  = 3'b110,
    OP_RSVD  = 3'b111
  } op_e;

  localparam logic [2:0] FS_DEC  = 3'b000;
  localparam logic [2:0] FS_INC  = 3'b001;
  localparam logic [2:0] FS_LOAD = 3'b010;
  localparam logic [2:0] FS_CLR  = 3'b011;

  // RegSel enables are active-low: bit2 PC, bit1 AR, bit0 SP
  localparam logic [2:0] RS_PC_EN  = 3'b011;
  localparam logic [2:0] RS_AR_EN  = 3'b101;
  localparam logic [2:0] RS_SP_EN  = 3'b110;
  localparam logic [2:0] RS_ALL_EN = 3'b000;
  localparam logic [2:0] RS_NONE   = 3'b111;

  localparam logic [1:0] OD_PC = 2'b00;
  localparam logic [1:0] OD_AR = 2'b10;
  localparam logic [1:0] OD_SP = 2'b11;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_S1   = 2'd1,
    ST_S2   = 2'd2,
    ST_S3   = 2'd3
  } state_e;

  typedef struct packed {
    logic [2:0] fun_sel;
    logic [2:0] reg_sel;
    logic [1:0] out_d_sel;
    logic       mem_read;
    logic       mem_write;
    logic       last;
  } ctrl_word_t;

  function automatic ctrl_word_t cw_make(input logic [2:0] fun_sel, input logic [2:0] reg_sel,
                                         input logic [1:0] out_d_sel, input logic mem_read,
                                         input logic mem_write, input logic last);
    ctrl_word_t cw;
    cw.fun_sel   = fun_sel;
    cw.reg_sel   = reg_sel;
    cw.out_d_sel = out_d_sel;
    cw.mem_read  = mem_read;
    cw.mem_write = mem_write;
    cw.last      = last;
    return cw;
  endfunction

endpackage

// File: rtl/arf_sequencer_if.sv
// Command handshake and register-file/memory control bundle between the instruction FSM
// (master) and the sequencer (slave).
interface arf_sequencer_if;
  logic       CmdValid;
  logic [2:0] CmdOp;
  logic       CmdReady;
  logic       MemWait;
  logic [2:0] FunSel;
  logic [2:0] RegSel;
  logic [1:0] OutDSel;
  logic       MemRead;
  logic       MemWrite;
  logic       Busy;
  logic       Done;

  modport master (
    output CmdValid, CmdOp, MemWait,
    input  CmdReady, FunSel, RegSel, OutDSel, MemRead, MemWrite, Busy, Done
  );

  modport slave (
    input  CmdValid, CmdOp, MemWait,
    output CmdReady, FunSel, RegSel, OutDSel, MemRead, MemWrite, Busy, Done
  );
endinterface

// File: rtl/arf_sequencer_step_decoder.sv
// Combinational map from (latched opcode, step) to the raw control word; MemWait and
// Reset gating are applied by the top level.
module arf_step_decoder
  import arf_ctrl_pkg::*;
#(
  parameter int WORD_BYTES = 2
) (
  input  op_e        op,
  input  state_e     state,
  output ctrl_word_t cw
);

  localparam bit     TWO       = (WORD_BYTES == 2);
  localparam state_e LAST_BYTE = TWO ? ST_S2 : ST_S1;

  logic byte_step;

  always_comb begin
    byte_step = (state == ST_S1) || (TWO && (state == ST_S2));
    cw        = cw_make(FS_DEC, RS_NONE, OD_PC, 1'b0, 1'b0, 1'b0);
    if (state != ST_IDLE) begin
      // Any step beyond an opcode's sequence does nothing and retires the command
      cw.last = 1'b1;
      case (op)
        OP_FETCH: if (byte_step) cw = cw_make(FS_INC, RS_PC_EN, OD_PC, 1'b1, 1'b0, state == LAST_BYTE);
        OP_PUSH:  if (byte_step) cw = cw_make(FS_DEC, RS_SP_EN, OD_SP, 1'b0, 1'b1, state == LAST_BYTE);
        OP_POP: begin
          // Pre-increment, then read each byte; the last read leaves SP alone
          case (state)
            ST_S1: cw = cw_make(FS_INC, RS_SP_EN, OD_SP, 1'b0, 1'b0, 1'b0);
            ST_S2: cw = TWO ? cw_make(FS_INC, RS_SP_EN, OD_SP, 1'b1, 1'b0, 1'b0)
                            : cw_make(FS_DEC, RS_NONE, OD_SP, 1'b1, 1'b0, 1'b1);
            ST_S3: if (TWO) cw = cw_make(FS_DEC, RS_NONE, OD_SP, 1'b1, 1'b0, 1'b1);
            default: ;
          endcase
        end
        OP_JUMP: if (state == ST_S1) cw = cw_make(FS_LOAD, RS_PC_EN, OD_PC, 1'b0, 1'b0, 1'b1);
        OP_LDAR: if (state == ST_S1) cw = cw_make(FS_LOAD, RS_AR_EN, OD_PC, 1'b0, 1'b0, 1'b1);
        OP_INIT: if (state == ST_S1) cw = cw_make(FS_CLR, RS_ALL_EN, OD_PC, 1'b0, 1'b0, 1'b1);
        default: ;
      endcase
    end
  end

endmodule

// File: rtl/arf_sequencer.sv
// Address register file sequencer: accepts one command at a time and steps it through
// the decoder, holding on MemWait and blocking register updates while stalled or in reset.
module arf_sequencer
  import arf_ctrl_pkg::*;
#(
  parameter int WORD_BYTES = 2
) (
  input  logic            Clock,
  input  logic            Reset,
  arf_sequencer_if.slave  bus
);

  state_e     state_q, state_d;
  op_e        op_q, op_d;
  ctrl_word_t cw;
  logic       idle;
  logic       stall;

  arf_step_decoder #(.WORD_BYTES(WORD_BYTES)) u_dec (
    .op    (op_q),
    .state (state_q),
    .cw    (cw)
  );

  always_comb begin
    idle    = (state_q == ST_IDLE);
    stall   = !idle && bus.MemWait;
    state_d = state_q;
    op_d    = op_q;
    if (idle) begin
      if (bus.CmdValid) begin
        state_d = ST_S1;
        op_d    = op_e'(bus.CmdOp);
      end
    end else if (!bus.MemWait) begin
      state_d = cw.last ? ST_IDLE : state_e'(state_q + 2'd1);
    end
  end

  always_ff @(posedge Clock) begin
    if (Reset) state_q <= ST_IDLE;
    else       state_q <= state_d;
  end

  always_ff @(posedge Clock) begin
    op_q <= op_d;
  end

  // A stalled step keeps its address and strobe but must not touch the registers
  assign bus.CmdReady = idle;
  assign bus.Busy     = !idle;
  assign bus.FunSel   = cw.fun_sel;
  assign bus.OutDSel  = cw.out_d_sel;
  assign bus.RegSel   = (Reset || stall) ? RS_NONE : cw.reg_sel;
  assign bus.MemRead  = !Reset && cw.mem_read;
  assign bus.MemWrite = !Reset && cw.mem_write;
  assign bus.Done     = !Reset && !idle && !bus.MemWait && cw.last;

endmodule

// File: tb/tb_arf_sequencer.sv
// Directed bench: a step-list model checks every output each cycle; a bench-side register
// file and memory-access log pin the end-to-end results with literal values.
module tb_arf_sequencer;
  import arf_ctrl_pkg::*;

  localparam int W = 2;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  arf_sequencer_if ifc ();

  arf_sequencer #(.WORD_BYTES(W)) dut (
    .Clock (clk),
    .Reset (rst),
    .bus   (ifc.slave)
  );

  typedef struct {
    logic [2:0] fun;
    logic [2:0] rs;
    logic [1:0] od;
    logic       rd;
    logic       wr;
  } step_t;

  step_t       exp_q[$];
  logic [16:0] mem_log[$];
  int          acc_cyc[$];
  logic [15:0] i_bus;
  logic [15:0] pc, ar, sp;
  logic [15:0] sp_load_val;
  int          sp_load_req = 0, sp_load_seen = 0;
  int          done_cnt = 0, busy_cnt = 0, cyc = 0;
  int          m_pass = 0, m_total = 0, l_pass = 0, l_total = 0;

  task automatic mchk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    m_total++;
    if (act === exp) m_pass++;
    else $display("FAIL %s @cyc %0d: got %h expected %h", nm, cyc, act, exp);
  endtask

  task automatic lchk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    l_total++;
    if (act === exp) l_pass++;
    else $display("FAIL %s: got %h expected %h", nm, act, exp);
  endtask

  task automatic add_step(input logic [2:0] f, input logic [2:0] rs, input logic [1:0] od,
                          input logic rd, input logic wr);
    step_t s;
    s.fun = f; s.rs = rs; s.od = od; s.rd = rd; s.wr = wr;
    exp_q.push_back(s);
  endtask

  // What each command must look like, step by step, written from the command table
  task automatic expand(input logic [2:0] op);
    case (op)
      3'b001: for (int k = 0; k < W; k++) add_step(3'b001, 3'b011, 2'b00, 1'b1, 1'b0);
      3'b010: for (int k = 0; k < W; k++) add_step(3'b000, 3'b110, 2'b11, 1'b0, 1'b1);
      3'b011: begin
        add_step(3'b001, 3'b110, 2'b11, 1'b0, 1'b0);
        if (W == 2) add_step(3'b001, 3'b110, 2'b11, 1'b1, 1'b0);
        add_step(3'b000, 3'b111, 2'b11, 1'b1, 1'b0);
      end
      3'b100: add_step(3'b010, 3'b011, 2'b00, 1'b0, 1'b0);
      3'b101: add_step(3'b010, 3'b101, 2'b00, 1'b0, 1'b0);
      3'b110: add_step(3'b011, 3'b000, 2'b00, 1'b0, 1'b0);
      default: add_step(3'b000, 3'b111, 2'b00, 1'b0, 1'b0);
    endcase
  endtask

  function automatic logic [15:0] upd(input logic [15:0] v, input logic [2:0] f, input logic [15:0] ld);
    case (f)
      3'b000:  return v - 16'd1;
      3'b001:  return v + 16'd1;
      3'b010:  return ld;
      3'b011:  return 16'd0;
      default: return v;
    endcase
  endfunction

  // Compare process: outputs are stable at the falling edge
  always @(negedge clk) begin
    step_t       h;
    logic [15:0] addr;
    cyc++;
    if (rst) begin
      mchk("rst_regsel", ifc.RegSel, 3'b111);
      mchk("rst_memread", ifc.MemRead, 1'b0);
      mchk("rst_memwrite", ifc.MemWrite, 1'b0);
      mchk("rst_done", ifc.Done, 1'b0);
      mchk("rst_busy", ifc.Busy, exp_q.size() != 0);
    end else if (exp_q.size() == 0) begin
      mchk("idle_busy", ifc.Busy, 1'b0);
      mchk("idle_ready", ifc.CmdReady, 1'b1);
      mchk("idle_funsel", ifc.FunSel, 3'b000);
      mchk("idle_regsel", ifc.RegSel, 3'b111);
      mchk("idle_outdsel", ifc.OutDSel, 2'b00);
      mchk("idle_memread", ifc.MemRead, 1'b0);
      mchk("idle_memwrite", ifc.MemWrite, 1'b0);
      mchk("idle_done", ifc.Done, 1'b0);
    end else begin
      h = exp_q[0];
      mchk("step_busy", ifc.Busy, 1'b1);
      mchk("step_ready", ifc.CmdReady, 1'b0);
      mchk("step_funsel", ifc.FunSel, h.fun);
      mchk("step_outdsel", ifc.OutDSel, h.od);
      mchk("step_regsel", ifc.RegSel, ifc.MemWait ? 3'b111 : h.rs);
      mchk("step_memread", ifc.MemRead, h.rd);
      mchk("step_memwrite", ifc.MemWrite, h.wr);
      mchk("step_done", ifc.Done, !ifc.MemWait && exp_q.size() == 1);
    end
    if (ifc.Done) done_cnt++;
    if (ifc.Busy) busy_cnt++;
    // Bench-side register file and memory port, driven by the DUT outputs
    case (ifc.OutDSel)
      2'b10:   addr = ar;
      2'b11:   addr = sp;
      default: addr = pc;
    endcase
    if ((ifc.MemRead || ifc.MemWrite) && !ifc.MemWait) mem_log.push_back({ifc.MemWrite, addr});
    if (!ifc.RegSel[2]) pc = upd(pc, ifc.FunSel, i_bus);
    if (!ifc.RegSel[1]) ar = upd(ar, ifc.FunSel, i_bus);
    if (!ifc.RegSel[0]) sp = upd(sp, ifc.FunSel, i_bus);
    if (sp_load_seen != sp_load_req) begin
      sp = sp_load_val;
      sp_load_seen = sp_load_req;
    end
    if (rst) exp_q.delete();
    else if (exp_q.size() != 0) begin
      if (!ifc.MemWait) void'(exp_q.pop_front());
    end else if (ifc.CmdValid) begin
      expand(ifc.CmdOp);
      acc_cyc.push_back(cyc);
    end
  end

  // All callers run at posedge+1; returns at posedge+1 with the command accepted
  task automatic start_cmd(input logic [2:0] op, input logic [15:0] ival);
    int n;
    n = 0;
    ifc.CmdValid = 1'b1;
    ifc.CmdOp    = op;
    i_bus        = ival;
    while (!ifc.CmdReady && n < 40) begin
      @(posedge clk); #1;
      n++;
    end
    lchk("cmd_ready", ifc.CmdReady, 1'b1);
    @(posedge clk); #1;
  endtask

  task automatic wait_idle();
    int n;
    n = 0;
    while (ifc.Busy && n < 40) begin
      @(posedge clk); #1;
      n++;
    end
    lchk("busy_clear", ifc.Busy, 1'b0);
  endtask

  task automatic run_cmd(input logic [2:0] op, input logic [15:0] ival, input int stall);
    logic [15:0] pc0;
    start_cmd(op, ival);
    ifc.CmdValid = 1'b0;
    if (stall > 0) begin
      pc0 = pc;
      ifc.MemWait = 1'b1;
      repeat (stall) begin @(posedge clk); #1; end
      lchk("stall_pc_hold", pc, pc0);
      ifc.MemWait = 1'b0;
    end
    wait_idle();
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int m0, d0, b0, a0, n;
    rst = 1'b1;
    ifc.CmdValid = 1'b0;
    ifc.CmdOp    = 3'b000;
    ifc.MemWait  = 1'b0;
    i_bus        = 16'h0000;
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
    @(posedge clk); #1;
    lchk("reset_ready", ifc.CmdReady, 1'b1);
    lchk("reset_busy", ifc.Busy, 1'b0);

    // INIT, JUMP 0x0100, FETCH
    run_cmd(3'b110, 16'h0000, 0);
    lchk("init_pc", pc, 16'h0000);
    lchk("init_ar", ar, 16'h0000);
    lchk("init_sp", sp, 16'h0000);
    run_cmd(3'b100, 16'h0100, 0);
    lchk("jump_pc", pc, 16'h0100);
    m0 = mem_log.size(); d0 = done_cnt;
    run_cmd(3'b001, 16'h0000, 0);
    lchk("fetch_pc", pc, 16'h0102);
    lchk("fetch_nacc", mem_log.size() - m0, 2);
    lchk("fetch_rd0", mem_log[m0], {1'b0, 16'h0100});
    lchk("fetch_rd1", mem_log[m0+1], {1'b0, 16'h0101});
    lchk("fetch_done", done_cnt - d0, 1);

    // PUSH / POP around SP=0x00FF
    sp_load_val = 16'h00FF; sp_load_req++;
    @(posedge clk); #1;
    lchk("sp_preload", sp, 16'h00FF);
    m0 = mem_log.size(); d0 = done_cnt;
    run_cmd(3'b010, 16'h0000, 0);
    lchk("push_sp", sp, 16'h00FD);
    lchk("push_wr0", mem_log[m0], {1'b1, 16'h00FF});
    lchk("push_wr1", mem_log[m0+1], {1'b1, 16'h00FE});
    lchk("push_done", done_cnt - d0, 1);
    m0 = mem_log.size(); d0 = done_cnt;
    run_cmd(3'b011, 16'h0000, 0);
    lchk("pop_sp", sp, 16'h00FF);
    lchk("pop_nacc", mem_log.size() - m0, 2);
    lchk("pop_rd0", mem_log[m0], {1'b0, 16'h00FE});
    lchk("pop_rd1", mem_log[m0+1], {1'b0, 16'h00FF});
    lchk("pop_done", done_cnt - d0, 1);

    // FETCH stalled three cycles in its first step
    b0 = busy_cnt;
    run_cmd(3'b001, 16'h0000, 3);
    lchk("stall_pc", pc, 16'h0104);
    lchk("stall_busy_cycles", busy_cnt - b0, 5);

    // LDAR with CmdValid held into a following FETCH
    a0 = acc_cyc.size();
    start_cmd(3'b101, 16'hBEEF);
    ifc.CmdOp = 3'b001;
    n = 0;
    while (acc_cyc.size() < a0 + 2 && n < 40) begin
      @(posedge clk); #1;
      n++;
    end
    ifc.CmdValid = 1'b0;
    wait_idle();
    lchk("ldar_ar", ar, 16'hBEEF);
    lchk("held_accept_gap", acc_cyc[a0+1] - acc_cyc[a0], 2);
    lchk("held_fetch_pc", pc, 16'h0106);

    // Reset during the second byte of a PUSH keeps the first decrement
    start_cmd(3'b010, 16'h0000);
    ifc.CmdValid = 1'b0;
    @(posedge clk); #1;
    rst = 1'b1;
    repeat (2) begin @(posedge clk); #1; end
    rst = 1'b0;
    lchk("abort_busy", ifc.Busy, 1'b0);
    lchk("abort_ready", ifc.CmdReady, 1'b1);
    lchk("abort_sp", sp, 16'h00FE);

    // PC wrap and reserved opcode
    run_cmd(3'b110, 16'h0000, 0);
    lchk("init2_sp", sp, 16'h0000);
    run_cmd(3'b100, 16'hFFFF, 0);
    m0 = mem_log.size();
    run_cmd(3'b001, 16'h0000, 0);
    lchk("wrap_pc", pc, 16'h0001);
    lchk("wrap_rd0", mem_log[m0], {1'b0, 16'hFFFF});
    lchk("wrap_rd1", mem_log[m0+1], {1'b0, 16'h0000});
    d0 = done_cnt; m0 = mem_log.size();
    run_cmd(3'b111, 16'h1234, 0);
    lchk("rsvd_done", done_cnt - d0, 1);
    lchk("rsvd_pc", pc, 16'h0001);
    lchk("rsvd_ar", ar, 16'h0000);
    lchk("rsvd_sp", sp, 16'h0000);
    lchk("rsvd_nacc", mem_log.size() - m0, 0);

    @(posedge clk); #1;
    $display("%0d/%0d checks passed", m_pass + l_pass, m_total + l_total);
    $finish;
  end

endmodule

// File: doc/arf_sequencer.md
Name: arf_sequencer

Overview:
- Command-driven controller for the address register file (PC, AR, SP) and its memory-address port.
- Accepts one command at a time on a valid/ready handshake and expands it into a per-cycle sequence of FunSel, RegSel, OutDSel and memory strobes.
- Covers instruction fetch, stack push/pop, PC jump, AR load and register initialisation.
- Sits between the instruction-control FSM and the address register file; OutCSel is not driven by this block.

Parameters:
- WORD_BYTES, 2, bytes moved per FETCH/PUSH/POP; legal values 1 or 2.

Ports:
- Clock  input  1  system clock; all state updates on the rising edge.
- Reset  input  1  synchronous, active-high reset.
- CmdValid  input  1  command present.
- CmdOp  input  3  opcode: 000 NOP, 001 FETCH, 010 PUSH, 011 POP, 100 JUMP, 101 LDAR, 110 INIT, 111 reserved (treated as NOP).
- CmdReady  output  1  high only in IDLE; a command is accepted when CmdValid && CmdReady at a rising edge.
- MemWait  input  1  memory not ready; stalls the current step.
- FunSel  output  3  to address register file; 000 dec, 001 inc, 010 load, 011 clear.
- RegSel  output  3  active-low enables; bit2 PC, bit1 AR, bit0 SP.
- OutDSel  output  2  memory address source; 00 PC, 10 AR, 11 SP.
- MemRead  output  1  read strobe for the current step.
- MemWrite  output  1  write strobe for the current step.
- Busy  output  1  high whenever the state is not IDLE.
- Done  output  1  high in the final step of a command when MemWait=0.

Behaviour:
- Reset:
  - State goes to IDLE at the first rising edge with Reset=1.
  - While Reset=1, outputs are forced combinationally to RegSel=111, MemRead=0, MemWrite=0, Done=0.
- IDLE outputs:
  - RegSel=111, FunSel=000, OutDSel=00, MemRead=0, MemWrite=0, Busy=0, Done=0, CmdReady=1.
- Command capture:
  - The opcode is latched at acceptance. Step 1 executes in the cycle after acceptance (one-cycle latency).
  - CmdOp is ignored while Busy=1.
- FSM states: IDLE, S1, S2, S3.
  - Each step advances to the next step only when MemWait=0.
  - The final step returns to IDLE.
- Step sequences for W=WORD_BYTES (for W=1, drop the repeated byte step):
  - FETCH: S1 = OutDSel=00, MemRead, PC inc (FunSel 001, RegSel 011). S2 repeats S1. Done in S2. PC ends at PC+W.
  - PUSH: S1 = OutDSel=11, MemWrite, SP dec (FunSel 000, RegSel 110). S2 repeats S1. Done in S2. SP ends at SP−W; writes go to SP, then SP−1.
  - POP: S1 = SP inc, no strobe. S2 = OutDSel=11, MemRead, SP inc. S3 = OutDSel=11, MemRead, no register enable. Done in S3. Reads SP+1, then SP+2; SP ends at SP+W.
    - For W=1: S1 inc, then S2 read with no increment.
  - JUMP: S1 = FunSel 010, RegSel 011 (PC ← I). Done in S1.
  - LDAR: S1 = FunSel 010, RegSel 101 (AR ← I). Done in S1.
  - INIT: S1 = FunSel 011, RegSel 000 (clear PC, AR, SP). Done in S1.
  - NOP/reserved: S1 with all enables off. Done in S1.
- MemWait=1 during a step:
  - Hold state; keep OutDSel and the strobe asserted.
  - Force RegSel=111 so no register changes.
  - Done=0.
- Register arithmetic wraps mod 2^16 inside the register file; the sequencer does no address checking.
- Reset mid-command aborts it; the partial register updates already made are kept.
- A command arriving while Busy=1 is held by the requester: CmdReady=0, no loss, no queueing.
- Back-to-back commands: a new command can be accepted in the IDLE cycle right after Done, so there is at least one idle cycle between commands.

Decomposition:
- Shared package arf_ctrl_pkg holds:
  - opcode constants;
  - FunSel codes (DEC, INC, LOAD, CLR);
  - RegSel masks (PC_EN=011, AR_EN=101, SP_EN=110, ALL_EN=000, NONE=111);
  - OutDSel codes;
  - the state enumeration.
- Sub-module arf_step_decoder: purely combinational (latched op, state, WORD_BYTES) → control word. The top level keeps the FSM, the handshake and the MemWait/Reset gating.

Test Plan:
- Reset held 2 cycles mid-PUSH → state returns to IDLE, RegSel=111 with no strobes while Reset=1, CmdReady=1 after release.
- INIT, then JUMP with I=16'h0100, then FETCH (W=2), MemWait=0 → PC=0x0102; MemRead seen on 2 cycles with OutDSel=00; Done on the 2nd.
- SP=0x00FF, PUSH, then POP → writes at 0xFF and 0xFE with SP=0xFD; POP reads 0xFE and 0xFF with SP=0xFF; Done once per command.
- FETCH with MemWait=1 for 3 cycles in S1 → PC unchanged during the stall, MemRead held, PC=+2 only after the stall ends; total 5 busy cycles.
- LDAR with I=16'hBEEF while CmdValid is held for a 2nd command → AR=0xBEEF; 2nd command accepted only after IDLE is re-entered.
- INIT with all registers at 0 then FETCH from PC=0xFFFF (via JUMP I=16'hFFFF) → PC wraps to 0x0001; CmdOp=111 yields Done with no register change.
